// File: rtl/stack_program_driver_pkg.sv
// Shared constants for the stack CPU program driver: CPU opcodes,
// per-opcode slot padding, FSM state encoding and length helpers.
package stack_program_driver_pkg;

  // Stack CPU opcodes (4-bit nibble fetched on io_in[5:2])
  typedef enum logic [3:0] {
    OP_NOOP = 4'h0,
    OP_PUSH = 4'h1,
    OP_POP  = 4'h2,
    OP_OUTL = 4'h3,
    OP_OUTH = 4'h4,
    OP_SWAP = 4'h5,
    OP_PEEK = 4'h6,
    OP_DUP  = 4'h7,
    OP_AND  = 4'h8
  } opcode_e;

  // Playback FSM states
  typedef enum logic [2:0] {
    S_IDLE,
    S_CPURST,
    S_FETCH,
    S_OPERAND,
    S_PAD,
    S_FINISH
  } state_e;

  localparam int unsigned PROG_DEPTH = 16;
  localparam logic [4:0]  MAX_LEN    = 5'd16;

  // Cycles following the fetch cycle for each opcode (index = opcode).
  // PUSH uses its two cycles to present the operand; every other
  // two-cycle op and all one-cycle/undefined ops are padded with 4'h0.
  localparam logic [15:0][1:0] PAD_LEN = {
    2'd1, 2'd1, 2'd1, 2'd1,   // F E D C  (undefined)
    2'd1, 2'd1, 2'd1,         // B A 9    (undefined)
    2'd2,                     // 8 AND
    2'd2,                     // 7 DUP
    2'd2,                     // 6 PEEK
    2'd2,                     // 5 SWAP
    2'd1,                     // 4 OUTH
    2'd1,                     // 3 OUTL
    2'd2,                     // 2 POP
    2'd2,                     // 1 PUSH (operand cycles)
    2'd1                      // 0 NOOP
  };

  function automatic logic [1:0] slot_pad(input logic [3:0] op);
    return PAD_LEN[op];
  endfunction

  // Program lengths above the memory depth are clamped to the depth
  function automatic logic [4:0] sat_len(input logic [4:0] n);
    return (n > MAX_LEN) ? MAX_LEN : n;
  endfunction

endpackage

// File: rtl/stack_program_driver_if.sv
// Host-side bus of the program driver: program load, start/length,
// and status/result returned to the host.
interface stack_program_driver_if;
  logic       start;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [4:0] prog_len;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       trunc_err;

  modport master (
    output start, wr_en, wr_addr, wr_data, prog_len,
    input  busy, done, result, trunc_err
  );

  modport slave (
    input  start, wr_en, wr_addr, wr_data, prog_len,
    output busy, done, result, trunc_err
  );
endinterface

// File: rtl/stack_program_driver_program_memory.sv
// 16x4 program storage: synchronous write, combinational read, no reset
// so the program survives a driver reset.
module program_memory
  import stack_program_driver_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [3:0] rd_data
);

  logic [3:0] mem [PROG_DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_program_driver.sv
// Plays a stored nibble program into a stack CPU: resets the CPU, then
// feeds each opcode aligned to the CPU fetch cycle (operands for PUSH,
// zero padding for everything else) and captures the CPU output byte.
module stack_program_driver
  import stack_program_driver_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  stack_program_driver_if.slave        bus,
  output logic                         cpu_rst,
  output logic [3:0]                   cpu_inbits,
  output logic [1:0]                   cpu_output_mode,
  input  logic [7:0]                   cpu_out
);

  state_e     state, state_next;
  logic [4:0] pc;
  logic [4:0] len;
  logic [1:0] cnt;
  logic       trunc_q;
  logic [7:0] result_q;
  logic [3:0] rd_data;
  logic [3:0] inbits_c;
  logic       done_c;
  logic       idle;
  logic       operand_ok;
  logic [4:0] pc_step;

  assign idle       = (state == S_IDLE);
  // A PUSH in the last slot has no operand word behind it
  assign operand_ok = (pc < len);
  // pc only advances past an operand that actually exists, so it never
  // runs beyond the latched length
  assign pc_step    = operand_ok ? (pc + 5'd1) : pc;

  program_memory u_mem (
    .clk     (clk),
    .wr_en   (bus.wr_en & idle),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (pc[3:0]),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and Moore outputs
  always_comb begin
    state_next = state;
    inbits_c   = 4'h0;
    done_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) state_next = S_CPURST;
      end
      S_CPURST: begin
        state_next = (len == 5'd0) ? S_FINISH : S_FETCH;
      end
      S_FETCH: begin
        inbits_c   = rd_data;
        state_next = (rd_data == OP_PUSH) ? S_OPERAND : S_PAD;
      end
      S_OPERAND: begin
        inbits_c = operand_ok ? rd_data : 4'h0;
        if (cnt == 2'd0) state_next = (pc_step < len) ? S_FETCH : S_FINISH;
      end
      S_PAD: begin
        if (cnt == 2'd0) state_next = (pc < len) ? S_FETCH : S_FINISH;
      end
      S_FINISH: begin
        done_c     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Program counter, slot counter, status flags and result capture.
  // cpu_rst is registered from the next state so it is already high
  // throughout reset and drops on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      len      <= '0;
      cnt      <= '0;
      trunc_q  <= 1'b0;
      result_q <= '0;
      cpu_rst  <= 1'b1;
    end else begin
      cpu_rst <= (state_next == S_CPURST);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            len     <= sat_len(bus.prog_len);
            pc      <= '0;
            cnt     <= '0;
            trunc_q <= 1'b0;
          end
        end
        S_FETCH: begin
          pc  <= pc + 5'd1;
          cnt <= slot_pad(rd_data) - 2'd1;
        end
        S_OPERAND: begin
          if (!operand_ok) trunc_q <= 1'b1;
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
          else             pc  <= pc_step;
        end
        S_PAD: begin
          if (cnt != 2'd0) cnt <= cnt - 2'd1;
        end
        S_FINISH: begin
          result_q <= cpu_out;
        end
        default: ;
      endcase
    end
  end

  assign cpu_inbits      = inbits_c;
  assign cpu_output_mode = 2'b00;
  assign bus.busy        = ~idle;
  assign bus.done        = done_c;
  assign bus.result      = result_q;
  assign bus.trunc_err   = trunc_q;

endmodule

// File: tb/tb_stack_program_driver.sv
// Bench for stack_program_driver: a small behavioural stack CPU drives
// cpu_out, directed table vectors plus random programs are checked
// against a program-level reference model.
module tb_stack_program_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_rst;
  logic [3:0] cpu_inbits;
  logic [1:0] cpu_output_mode;
  logic [7:0] cpu_out;

  stack_program_driver_if bus ();

  stack_program_driver dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .cpu_rst         (cpu_rst),
    .cpu_inbits      (cpu_inbits),
    .cpu_output_mode (cpu_output_mode),
    .cpu_out         (cpu_out)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string what, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %0h, want %0h", what, tag, act, exp);
    end
  endtask

  // ---------------- behavioural stack CPU ----------------
  typedef struct packed {
    logic [15:0][3:0] stk;
    logic [4:0]       sp;
    logic [7:0]       out;
  } cpu_t;

  function automatic logic two_cyc(input logic [3:0] op);
    return (op == 4'h2) || (op >= 4'h5 && op <= 4'h8);
  endfunction

  function automatic cpu_t exec(input cpu_t s, input logic [3:0] op, input logic [3:0] arg);
    cpu_t r;
    logic [3:0] t1, t2, tmp;
    r  = s;
    t1 = r.sp[3:0] - 4'd1;
    t2 = r.sp[3:0] - 4'd2;
    case (op)
      4'h1: if (r.sp < 5'd16) begin r.stk[r.sp[3:0]] = arg; r.sp = r.sp + 5'd1; end
      4'h2: if (r.sp > 5'd0) r.sp = r.sp - 5'd1;
      4'h3: r.out[3:0] = (r.sp > 5'd0) ? r.stk[t1] : 4'h0;
      4'h4: r.out[7:4] = (r.sp > 5'd0) ? r.stk[t1] : 4'h0;
      4'h5: if (r.sp >= 5'd2) begin tmp = r.stk[t1]; r.stk[t1] = r.stk[t2]; r.stk[t2] = tmp; end
      4'h6: if (r.sp >= 5'd2 && r.sp < 5'd16) begin r.stk[r.sp[3:0]] = r.stk[t2]; r.sp = r.sp + 5'd1; end
      4'h7: if (r.sp >= 5'd1 && r.sp < 5'd16) begin r.stk[r.sp[3:0]] = r.stk[t1]; r.sp = r.sp + 5'd1; end
      4'h8: if (r.sp >= 5'd2) begin r.stk[t2] = r.stk[t2] & r.stk[t1]; r.sp = r.sp - 5'd1; end
      default: ;
    endcase
    return r;
  endfunction

  cpu_t       cst;
  logic [1:0] skip;
  logic       pend;

  // CPU fetch/execute timing: fetch, then 2 or 1 following cycles
  always @(posedge clk) begin
    if (cpu_rst) begin
      cst <= '0; skip <= 2'd0; pend <= 1'b0;
    end else if (skip != 2'd0) begin
      if (pend) cst <= exec(cst, 4'h1, cpu_inbits);
      pend <= 1'b0;
      skip <= skip - 2'd1;
    end else if (cpu_inbits == 4'h1) begin
      pend <= 1'b1; skip <= 2'd2;
    end else begin
      cst  <= exec(cst, cpu_inbits, 4'h0);
      skip <= two_cyc(cpu_inbits) ? 2'd2 : 2'd1;
    end
  end

  assign cpu_out = cst.out;

  // ---------------- reference model ----------------
  logic [3:0]  exp_seq[$];
  logic [7:0]  exp_res;
  logic        exp_trunc;

  task automatic ref_run(input logic [63:0] prog, input logic [4:0] len);
    int unsigned L, pc;
    logic [3:0]  op, arg;
    cpu_t        s;
    L = (len > 5'd16) ? 16 : int'(len);
    pc = 0; s = '0; exp_trunc = 1'b0;
    exp_seq.delete();
    while (pc < L) begin
      op = prog[pc*4 +: 4];
      pc++;
      exp_seq.push_back(op);
      if (op == 4'h1) begin
        if (pc < L) arg = prog[pc*4 +: 4];
        else begin arg = 4'h0; exp_trunc = 1'b1; end
        exp_seq.push_back(arg);
        exp_seq.push_back(arg);
        s = exec(s, 4'h1, arg);
        pc++;
      end else begin
        s = exec(s, op, 4'h0);
        exp_seq.push_back(4'h0);
        if (two_cyc(op)) exp_seq.push_back(4'h0);
      end
    end
    exp_res = s.out;
  endtask

  // ---------------- drivers / monitors ----------------
  logic [3:0]  got_seq[$];
  int unsigned rst_cycles;
  logic [7:0]  got_res;
  logic        got_trunc, got_trunc_start;

  task automatic load_prog(input logic [63:0] prog);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = prog[i*4 +: 4];
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic run_prog(input logic [4:0] len, input int tag);
    int ok;
    ok = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.prog_len = len;
    @(negedge clk);
    bus.start = 1'b0;
    got_trunc_start = bus.trunc_err;
    chk("busy_after_start", tag, 32'(bus.busy), 32'd1);
    rst_cycles = 0;
    got_seq.delete();
    for (int c = 0; c < 100; c++) begin
      if (bus.done) begin ok = 1; break; end
      if (cpu_rst) rst_cycles++;
      else got_seq.push_back(cpu_inbits);
      @(negedge clk);
    end
    chk("done_seen", tag, 32'(ok), 32'd1);
    got_trunc = bus.trunc_err;
    @(negedge clk);
    got_res = bus.result;
    chk("busy_cleared", tag, 32'(bus.busy), 32'd0);
    chk("done_one_cycle", tag, 32'(bus.done), 32'd0);
  endtask

  task automatic check_run(input int tag);
    int n;
    chk("cpu_rst_cycles", tag, 32'(rst_cycles), 32'd1);
    chk("seq_len", tag, 32'(got_seq.size()), 32'(exp_seq.size()));
    n = (got_seq.size() < exp_seq.size()) ? got_seq.size() : exp_seq.size();
    for (int k = 0; k < n; k++) chk("inbits", tag*100 + k, 32'(got_seq[k]), 32'(exp_seq[k]));
    chk("result", tag, 32'(got_res), 32'(exp_res));
    chk("trunc_err", tag, 32'(got_trunc), 32'(exp_trunc));
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [63:0] prog;   // word i at [4i+3:4i]
    logic [4:0]  len;
    logic [63:0] seq;    // expected cpu_inbits after cpu_rst, first at LSB
    logic [4:0]  n;
    logic [7:0]  res;
    logic        trunc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [63:0] rp;
    logic [4:0]  rl;
    int          idx, done_cnt;

    tbl[0] = '{64'h351,    5'd3, 64'h03551,       5'd5,  8'h05, 1'b0};
    tbl[1] = '{64'h452191, 5'd6, 64'h04005221991, 5'd11, 8'h90, 1'b0};
    tbl[2] = '{64'h38761,  5'd5, 64'h03008007661, 5'd11, 8'h06, 1'b0};
    tbl[3] = '{64'h1,      5'd0, 64'h0,           5'd0,  8'h00, 1'b0};
    tbl[4] = '{64'h13,     5'd2, 64'h00103,       5'd5,  8'h00, 1'b1};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.prog_len = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, 32'(bus.busy), 32'd0);
    chk("rst_done", 0, 32'(bus.done), 32'd0);
    chk("rst_cpu_rst", 0, 32'(cpu_rst), 32'd1);
    chk("rst_inbits", 0, 32'(cpu_inbits), 32'd0);
    chk("rst_result", 0, 32'(bus.result), 32'd0);
    chk("rst_trunc", 0, 32'(bus.trunc_err), 32'd0);
    chk("output_mode", 0, 32'(cpu_output_mode), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("cpu_rst_hold", 0, 32'(cpu_rst), 32'd1);
    @(negedge clk);
    chk("cpu_rst_idle", 0, 32'(cpu_rst), 32'd0);

    // table vectors
    for (int i = 0; i < 5; i++) begin
      load_prog(tbl[i].prog);
      run_prog(tbl[i].len, 10 + i);
      exp_seq.delete();
      for (int k = 0; k < int'(tbl[i].n); k++) exp_seq.push_back(tbl[i].seq[k*4 +: 4]);
      exp_res   = tbl[i].res;
      exp_trunc = tbl[i].trunc;
      check_run(10 + i);
    end

    // trunc_err is sticky while idle and cleared by the next start
    repeat (3) @(negedge clk);
    chk("trunc_sticky", 20, 32'(bus.trunc_err), 32'd1);
    run_prog(5'd0, 21);
    chk("trunc_clear_on_start", 21, 32'(got_trunc_start), 32'd0);
    chk("len0_cpu_rst", 21, 32'(rst_cycles), 32'd1);
    chk("len0_seq_len", 21, 32'(got_seq.size()), 32'd0);
    chk("len0_trunc", 21, 32'(got_trunc), 32'd0);

    // start and wr_en while busy are ignored
    load_prog(tbl[0].prog);
    @(negedge clk);
    bus.start = 1'b1; bus.prog_len = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    idx = -1;
    for (int c = 0; c < 50; c++) begin
      if (bus.done) begin idx = c; break; end
      if (c >= 1 && c <= 3) begin
        bus.start = 1'b1; bus.prog_len = 5'd1;
        bus.wr_en = 1'b1; bus.wr_addr = 4'h0; bus.wr_data = 4'hF;
      end else begin
        bus.start = 1'b0; bus.wr_en = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.wr_en = 1'b0;
    chk("busy_run_length", 30, 32'(idx), 32'd6);
    @(negedge clk);
    run_prog(5'd3, 31);
    ref_run(tbl[0].prog, 5'd3);
    check_run(31);

    // random programs, including lengths above 16
    for (int t = 0; t < 30; t++) begin
      for (int w = 0; w < 16; w++) rp[w*4 +: 4] = 4'($urandom_range(0, 15));
      rl = 5'($urandom_range(0, 31));
      load_prog(rp);
      ref_run(rp, rl);
      run_prog(rl, 100 + t);
      check_run(100 + t);
    end

    // reset mid-playback aborts with no done; program memory survives
    for (int w = 0; w < 16; w++) rp[w*4 +: 4] = 4'($urandom_range(0, 15));
    load_prog(rp);
    @(negedge clk);
    bus.start = 1'b1; bus.prog_len = 5'd16;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy_before_abort", 40, 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("abort_busy", 40, 32'(bus.busy), 32'd0);
    chk("abort_done", 40, 32'(bus.done), 32'd0);
    chk("abort_cpu_rst", 40, 32'(cpu_rst), 32'd1);
    chk("abort_inbits", 40, 32'(cpu_inbits), 32'd0);
    chk("abort_result", 40, 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("abort_no_done", 41, 32'(done_cnt), 32'd0);
    chk("abort_idle", 41, 32'(bus.busy), 32'd0);
    ref_run(rp, 5'd16);
    run_prog(5'd16, 42);
    check_run(42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
